// File: rtl/mcp_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mcp_control_unit
//  Brief    : Multicycle MIPS control FSM (Moore) with integrated ALU decoder.
//             Drives datapath enables and mux selects from the current state.
//             Optional macro MCP_CU_BNE_EN adds a BNE state (encoding 12).
//  Revision : 1.0 - initial release
// ============================================================================
module mcp_control_unit #(
    parameter int OP_W   = 6,
    parameter int ALUC_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [OP_W-1:0]   Opcode,
    input  logic [OP_W-1:0]   Funct,
    input  logic              Zero,
    output logic              IorD,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegDst,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        PCSrc,
    output logic              PCEn,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [3:0]        State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
`ifdef MCP_CU_BNE_EN
       ,S_BNE     = 4'd12
`endif
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef MCP_CU_BNE_EN
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif

    localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'b100010);
    localparam logic [OP_W-1:0] FN_AND = OP_W'(6'b100100);
    localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'b100101);
    localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'b101010);

    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(3'b010);
    localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(3'b110);
    localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(3'b000);
    localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3'b001);
    localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(3'b111);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
`ifdef MCP_CU_BNE_EN
    logic       branch_ne;
`endif

    // State register: reset always returns to FETCH, dropping any partial instruction.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic and Moore outputs decoded from the current state.
    always_comb begin
        state_d       = S_FETCH;
        IorD          = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSrc         = 2'b00;
        alu_op        = 2'b00;
        pc_write      = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
`ifdef MCP_CU_BNE_EN
        branch_ne     = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                ALUSrcB      = 2'b01;
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MCP_CU_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
`ifdef MCP_CU_BNE_EN
            S_BNE: begin
                ALUSrcA   = 1'b1;
                alu_op    = 2'b01;
                PCSrc     = 2'b01;
                branch_ne = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // ALU decoder: ALUOp selects add/sub directly, or defers to Funct for R-type.
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            2'b01: ALUControl = ALU_SUB;
            2'b10: begin
                case (Funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    // Write enables are masked while RST is high so the reset edge cannot corrupt state.
    assign IRWrite  = ir_write_raw  & ~RST;
    assign MemWrite = mem_write_raw & ~RST;
    assign RegWrite = reg_write_raw & ~RST;
`ifdef MCP_CU_BNE_EN
    assign PCEn     = (pc_write | (branch & Zero) | (branch_ne & ~Zero)) & ~RST;
`else
    assign PCEn     = (pc_write | (branch & Zero)) & ~RST;
`endif
    assign State    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mcp_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcp_control_unit
//  Brief    : Table-driven per-cycle check of mcp_control_unit state and
//             control outputs, plus latency and held-reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mcp_control_unit;

    logic       CLK;
    logic       RST;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    mcp_control_unit #(.OP_W(6), .ALUC_W(3)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl),
        .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic [3:0]  st;
        logic [14:0] ctrl;
    } vec_t;

    vec_t vecs[$];

    // {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUControl}
    function automatic logic [14:0] cv(input logic iord, input logic mw, input logic irw,
                                       input logic rd, input logic mtr, input logic rw,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [1:0] pcs, input logic pcen,
                                       input logic [2:0] aluc);
        return {iord, mw, irw, rd, mtr, rw, sa, sb, pcs, pcen, aluc};
    endfunction

    function automatic logic [14:0] dut_ctrl();
        return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, PCSrc, PCEn, ALUControl};
    endfunction

    task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic [3:0] st, input logic [14:0] ctrl);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.zero = z; v.st = st; v.ctrl = ctrl;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [14:0] got,
                         input logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %b expected %b", name, idx, got, exp);
        end
    endtask

    // Counts posedges from FETCH until State returns to 0, with a cycle budget.
    task automatic latency(input string name, input logic [5:0] op, input int exp_cyc);
        int cyc;
        check({name, "_start"}, 0, {11'd0, State}, 15'd0);
        RST = 1'b0; Opcode = op; Funct = 6'd0; Zero = 1'b0;
        cyc = 0;
        do begin
            @(posedge CLK); #1;
            cyc++;
        end while (State != 4'd0 && cyc < 20);
        check({name, "_latency"}, 0, 15'(cyc), 15'(exp_cyc));
    endtask

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BNE = 6'b000101, OP_BAD = 6'b111111;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] k_fetch, k_fetch_rst, k_dec, k_madr, k_mrd, k_mwb, k_mwb_rst;
        logic [14:0] k_mwr, k_mwr_rst, k_awb, k_awb_rst, k_aex, k_aiwb, k_jmp;

        k_fetch     = cv(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010);
        k_fetch_rst = cv(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010);
        k_dec       = cv(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010);
        k_madr      = cv(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010);
        k_mrd       = cv(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b010);
        k_mwb       = cv(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b010);
        k_mwb_rst   = cv(0,0,0,0,1,0,0,2'b00,2'b00,0,3'b010);
        k_mwr       = cv(1,1,0,0,0,0,0,2'b00,2'b00,0,3'b010);
        k_mwr_rst   = cv(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b010);
        k_awb       = cv(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b010);
        k_awb_rst   = cv(0,0,0,1,0,0,0,2'b00,2'b00,0,3'b010);
        k_aex       = cv(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010);
        k_aiwb      = cv(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010);
        k_jmp       = cv(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010);

        // Reset state with enables forced low
        add(1, OP_LW, 0, 0, 0, k_fetch_rst);
        // lw
        add(0, OP_LW, 0, 0, 0, k_fetch);
        add(0, OP_LW, 0, 0, 1, k_dec);
        add(0, OP_LW, 0, 0, 2, k_madr);
        add(0, OP_LW, 0, 0, 3, k_mrd);
        add(0, OP_LW, 0, 0, 4, k_mwb);
        // sw
        add(0, OP_SW, 0, 0, 0, k_fetch);
        add(0, OP_SW, 0, 0, 1, k_dec);
        add(0, OP_SW, 0, 0, 2, k_madr);
        add(0, OP_SW, 0, 0, 5, k_mwr);
        // R-type: slt, sub, and, or, unknown funct
        add(0, OP_R, 6'b101010, 0, 0, k_fetch);
        add(0, OP_R, 6'b101010, 0, 1, k_dec);
        add(0, OP_R, 6'b101010, 0, 6, cv(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b111));
        add(0, OP_R, 6'b101010, 0, 7, k_awb);
        add(0, OP_R, 6'b100010, 1, 0, k_fetch);
        add(0, OP_R, 6'b100010, 1, 1, k_dec);
        add(0, OP_R, 6'b100010, 1, 6, cv(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b110));
        add(0, OP_R, 6'b100010, 1, 7, k_awb);
        add(0, OP_R, 6'b100100, 0, 0, k_fetch);
        add(0, OP_R, 6'b100100, 0, 1, k_dec);
        add(0, OP_R, 6'b100100, 0, 6, cv(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b000));
        add(0, OP_R, 6'b100100, 0, 7, k_awb);
        add(0, OP_R, 6'b100101, 0, 0, k_fetch);
        add(0, OP_R, 6'b100101, 0, 1, k_dec);
        add(0, OP_R, 6'b100101, 0, 6, cv(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b001));
        add(0, OP_R, 6'b100101, 0, 7, k_awb);
        add(0, OP_R, 6'b000111, 0, 0, k_fetch);
        add(0, OP_R, 6'b000111, 0, 1, k_dec);
        add(0, OP_R, 6'b000111, 0, 6, cv(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b010));
        add(0, OP_R, 6'b000111, 0, 7, k_awb);
        // addi
        add(0, OP_ADDI, 0, 0, 0, k_fetch);
        add(0, OP_ADDI, 0, 0, 1, k_dec);
        add(0, OP_ADDI, 0, 0, 9, k_aex);
        add(0, OP_ADDI, 0, 0, 10, k_aiwb);
        // beq taken, then not taken
        add(0, OP_BEQ, 0, 1, 0, k_fetch);
        add(0, OP_BEQ, 0, 1, 1, k_dec);
        add(0, OP_BEQ, 0, 1, 8, cv(0,0,0,0,0,0,1,2'b00,2'b01,1,3'b110));
        add(0, OP_BEQ, 0, 0, 0, k_fetch);
        add(0, OP_BEQ, 0, 0, 1, k_dec);
        add(0, OP_BEQ, 0, 0, 8, cv(0,0,0,0,0,0,1,2'b00,2'b01,0,3'b110));
        // j
        add(0, OP_J, 0, 0, 0, k_fetch);
        add(0, OP_J, 0, 0, 1, k_dec);
        add(0, OP_J, 0, 0, 11, k_jmp);
        // unknown opcode: back to FETCH with no writes
        add(0, OP_BAD, 0, 0, 0, k_fetch);
        add(0, OP_BAD, 0, 0, 1, k_dec);
        // bne
`ifdef MCP_CU_BNE_EN
        add(0, OP_BNE, 0, 0, 0, k_fetch);
        add(0, OP_BNE, 0, 0, 1, k_dec);
        add(0, OP_BNE, 0, 0, 12, cv(0,0,0,0,0,0,1,2'b00,2'b01,1,3'b110));
        add(0, OP_BNE, 0, 1, 0, k_fetch);
        add(0, OP_BNE, 0, 1, 1, k_dec);
        add(0, OP_BNE, 0, 1, 12, cv(0,0,0,0,0,0,1,2'b00,2'b01,0,3'b110));
`else
        add(0, OP_BNE, 0, 0, 0, k_fetch);
        add(0, OP_BNE, 0, 0, 1, k_dec);
`endif
        // Reset held for 2 cycles starting in ALUWB
        add(0, OP_R, 6'b101010, 0, 0, k_fetch);
        add(0, OP_R, 6'b101010, 0, 1, k_dec);
        add(0, OP_R, 6'b101010, 0, 6, cv(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b111));
        add(1, OP_R, 6'b101010, 0, 7, k_awb_rst);
        add(1, OP_R, 6'b101010, 0, 0, k_fetch_rst);
        // Reset during MEMWR and MEMWB masks the writes and restarts at FETCH
        add(0, OP_SW, 0, 0, 0, k_fetch);
        add(0, OP_SW, 0, 0, 1, k_dec);
        add(0, OP_SW, 0, 0, 2, k_madr);
        add(1, OP_SW, 0, 0, 5, k_mwr_rst);
        add(0, OP_LW, 0, 0, 0, k_fetch);
        add(0, OP_LW, 0, 0, 1, k_dec);
        add(0, OP_LW, 0, 0, 2, k_madr);
        add(0, OP_LW, 0, 0, 3, k_mrd);
        add(1, OP_LW, 0, 0, 4, k_mwb_rst);
        // Clean exit through an unknown opcode, ending in FETCH
        add(0, OP_BAD, 0, 0, 0, k_fetch);
        add(0, OP_BAD, 0, 0, 1, k_dec);

        RST = 1'b1; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            RST = vecs[i].rst; Opcode = vecs[i].op; Funct = vecs[i].fn; Zero = vecs[i].zero;
            #1;
            check("state", i, {11'd0, State}, {11'd0, vecs[i].st});
            check("ctrl", i, dut_ctrl(), vecs[i].ctrl);
            @(posedge CLK); #1;
        end

        latency("lw", OP_LW, 5);
        latency("sw", OP_SW, 4);
        latency("rtype", OP_R, 4);
        latency("addi", OP_ADDI, 4);
        latency("beq", OP_BEQ, 3);
        latency("j", OP_J, 3);
        latency("unknown", OP_BAD, 2);
`ifdef MCP_CU_BNE_EN
        latency("bne", OP_BNE, 3);
`else
        latency("bne_off", OP_BNE, 2);
`endif

        // Reset held for several cycles keeps FETCH and all enables low
        RST = 1'b1; Opcode = OP_LW; Zero = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            check("held_rst_state", c, {11'd0, State}, 15'd0);
            check("held_rst_en", c, {11'd0, IRWrite, PCEn, MemWrite, RegWrite}, 15'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
